// File: rtl/synth_pkg.sv
// Shared types and constants for the keypad synth voice path.
package synth_pkg;

  localparam int unsigned NUM_NOTES      = 16;
  localparam int unsigned NUM_VOICES_DEF = 4;
  localparam int unsigned NOTE_W_DEF     = 4;

  typedef logic [NOTE_W_DEF-1:0] note_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    COMMIT = 2'd2
  } alloc_state_e;

endpackage

// File: rtl/voice_allocator_if.sv
// Note event handshake: producer (keypad decoder) is master, allocator is slave.
interface voice_allocator_if #(
  parameter int unsigned NOTE_W = 4
) ();

  logic              evt_valid_i;
  logic              evt_ready_o;
  logic              evt_on_i;
  logic [NOTE_W-1:0] evt_note_i;

  modport master (
    output evt_valid_i,
    output evt_on_i,
    output evt_note_i,
    input  evt_ready_o
  );

  modport slave (
    input  evt_valid_i,
    input  evt_on_i,
    input  evt_note_i,
    output evt_ready_o
  );

endinterface

// File: rtl/voice_allocator_oldest_voice_finder.sv
// Picks the active slot with the largest age; ties go to the lowest index.
module oldest_voice_finder #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AGE_W      = 4,
  parameter int unsigned IDX_W      = 2
) (
  input  logic [NUM_VOICES-1:0]       active_i,
  input  logic [NUM_VOICES*AGE_W-1:0] age_i,
  output logic [IDX_W-1:0]            idx_o,
  output logic                        valid_o
);

  logic [AGE_W-1:0] best_age;

  // Linear scan; strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_age = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (active_i[i] && (!valid_o || (age_i[i*AGE_W +: AGE_W] > best_age))) begin
        best_age = age_i[i*AGE_W +: AGE_W];
        idx_o    = IDX_W'(i);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic note-to-voice scheduler: reuse matching slot, else free slot,
// else steal the oldest active slot.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
  parameter int unsigned NOTE_W     = 4,
  parameter int unsigned AGE_W      = 4
) (
  input  logic                         clk_48kHz,
  input  logic                         rst_n,
  voice_allocator_if.slave             evt,
  output logic [NUM_VOICES-1:0]        voice_active_o,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note_o,
  output logic [NUM_VOICES-1:0]        voice_trig_o,
  output logic                         steal_o
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  alloc_state_e      state_q;
  logic              ready_q;
  logic              on_q;
  logic [NOTE_W-1:0] note_q;

  logic              match_vld_q, free_vld_q;
  logic [IDX_W-1:0]  match_idx_q, free_idx_q, old_idx_q;

  logic [NUM_VOICES-1:0] active_q;
  logic [NOTE_W-1:0]     notes_q [NUM_VOICES];
  logic [AGE_W-1:0]      ages_q  [NUM_VOICES];
  logic [NUM_VOICES-1:0] trig_q;
  logic                  steal_q;

  logic                        match_vld_c, free_vld_c, old_vld_c, steal_c;
  logic [IDX_W-1:0]            match_idx_c, free_idx_c, old_idx_c, tgt_idx_c;
  logic [NUM_VOICES-1:0]       trig_c;
  logic [NUM_VOICES*AGE_W-1:0] ages_flat;

  function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
    return (a == '1) ? a : a + AGE_W'(1);
  endfunction

  // Flatten ages for the finder and notes for the output bus.
  always_comb begin
    ages_flat    = '0;
    voice_note_o = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      ages_flat[v*AGE_W +: AGE_W]     = ages_q[v];
      voice_note_o[v*NOTE_W +: NOTE_W] = notes_q[v];
    end
  end

  oldest_voice_finder #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W),
    .IDX_W      (IDX_W)
  ) u_oldest (
    .active_i (active_q),
    .age_i    (ages_flat),
    .idx_o    (old_idx_c),
    .valid_o  (old_vld_c)
  );

  // Lowest active slot holding the captured note, lowest inactive slot.
  always_comb begin
    match_vld_c = 1'b0;
    match_idx_c = '0;
    free_vld_c  = 1'b0;
    free_idx_c  = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (!match_vld_c && active_q[v] && (notes_q[v] == note_q)) begin
        match_vld_c = 1'b1;
        match_idx_c = IDX_W'(v);
      end
      if (!free_vld_c && !active_q[v]) begin
        free_vld_c = 1'b1;
        free_idx_c = IDX_W'(v);
      end
    end
  end

  // Pulses are decided from the same lookup values that LOOKUP registers, so
  // they can be registered on entry to COMMIT and stay high for that cycle only.
  always_comb begin
    trig_c  = '0;
    steal_c = 1'b0;
    if (on_q) begin
      if (match_vld_c)     trig_c[match_idx_c] = 1'b1;
      else if (free_vld_c) trig_c[free_idx_c]  = 1'b1;
      else if (old_vld_c) begin
        trig_c[old_idx_c] = 1'b1;
        steal_c           = 1'b1;
      end
    end
  end

  // Note-on target slot from the registered lookup results.
  always_comb begin
    tgt_idx_c = old_idx_q;
    if (match_vld_q)     tgt_idx_c = match_idx_q;
    else if (free_vld_q) tgt_idx_c = free_idx_q;
  end

  // Allocator FSM plus slot state; all outputs registered.
  always_ff @(posedge clk_48kHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      on_q        <= 1'b0;
      note_q      <= '0;
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
      old_idx_q   <= '0;
      active_q    <= '0;
      trig_q      <= '0;
      steal_q     <= 1'b0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        notes_q[v] <= '0;
        ages_q[v]  <= '0;
      end
    end else begin
      trig_q  <= '0;
      steal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (evt.evt_valid_i && ready_q) begin
            on_q    <= evt.evt_on_i;
            note_q  <= evt.evt_note_i;
            ready_q <= 1'b0;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          match_vld_q <= match_vld_c;
          match_idx_q <= match_idx_c;
          free_vld_q  <= free_vld_c;
          free_idx_q  <= free_idx_c;
          old_idx_q   <= old_idx_c;
          trig_q      <= trig_c;
          steal_q     <= steal_c;
          state_q     <= COMMIT;
        end
        COMMIT: begin
          if (on_q) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
              if (IDX_W'(v) == tgt_idx_c) begin
                active_q[v] <= 1'b1;
                notes_q[v]  <= note_q;
                ages_q[v]   <= '0;
              end else if (active_q[v]) begin
                ages_q[v] <= sat_inc(ages_q[v]);
              end
            end
          end else if (match_vld_q) begin
            active_q[match_idx_q] <= 1'b0;
            ages_q[match_idx_q]   <= '0;
          end
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign evt.evt_ready_o = ready_q;
  assign voice_active_o  = active_q;
  assign voice_trig_o    = trig_q;
  assign steal_o         = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (NUM_VOICES=4, NOTE_W=4, AGE_W=4).
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  act, trig;
  logic [15:0] notes;
  logic        steal;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          hs_cnt  = 0;
  int          hs_ref;

  always #5 clk = ~clk;

  voice_allocator_if #(.NOTE_W(4)) evt_if ();

  voice_allocator #(
    .NUM_VOICES (4),
    .NOTE_W     (4),
    .AGE_W      (4)
  ) dut (
    .clk_48kHz      (clk),
    .rst_n          (rst_n),
    .evt            (evt_if),
    .voice_active_o (act),
    .voice_note_o   (notes),
    .voice_trig_o   (trig),
    .steal_o        (steal)
  );

  always @(posedge clk)
    if (rst_n && evt_if.evt_valid_i && evt_if.evt_ready_o) hs_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    evt_if.evt_valid_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One event: checks ready/pulse timing in LOOKUP, COMMIT and back in IDLE.
  task automatic send_evt(input logic on, input logic [3:0] note,
                          input logic [3:0] exp_trig, input logic exp_steal,
                          input bit hold);
    int waited = 0;
    @(negedge clk);
    evt_if.evt_on_i    = on;
    evt_if.evt_note_i  = note;
    evt_if.evt_valid_i = 1'b1;
    while (!evt_if.evt_ready_o && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!evt_if.evt_ready_o) begin
      chk("ready_timeout", 32'd0, 32'd1);
      evt_if.evt_valid_i = 1'b0;
      return;
    end
    @(negedge clk);
    if (!hold) evt_if.evt_valid_i = 1'b0;
    chk("lookup_ready", evt_if.evt_ready_o, 1'b0);
    chk("lookup_trig", trig, 4'b0000);
    @(negedge clk);
    chk("commit_ready", evt_if.evt_ready_o, 1'b0);
    chk("commit_trig", trig, exp_trig);
    chk("commit_steal", steal, exp_steal);
    @(negedge clk);
    evt_if.evt_valid_i = 1'b0;
    chk("idle_ready", evt_if.evt_ready_o, 1'b1);
    chk("idle_trig", trig, 4'b0000);
    chk("idle_steal", steal, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    evt_if.evt_valid_i = 1'b0;
    evt_if.evt_on_i    = 1'b0;
    evt_if.evt_note_i  = '0;
    repeat (2) @(negedge clk);
    chk("rst_active", act, 4'b0000);
    chk("rst_notes", notes, 16'h0000);
    chk("rst_trig", trig, 4'b0000);
    chk("rst_steal", steal, 1'b0);
    chk("rst_ready", evt_if.evt_ready_o, 1'b1);
    rst_n = 1'b1;

    // T1: reset asserted during the COMMIT cycle aborts the event
    @(negedge clk);
    evt_if.evt_on_i = 1'b1; evt_if.evt_note_i = 4'd3; evt_if.evt_valid_i = 1'b1;
    @(negedge clk);
    evt_if.evt_valid_i = 1'b0;
    @(negedge clk);
    chk("t1_commit_trig", trig, 4'b0001);
    #1 rst_n = 1'b0;
    #1;
    chk("t1_active", act, 4'b0000);
    chk("t1_notes", notes, 16'h0000);
    chk("t1_trig", trig, 4'b0000);
    chk("t1_steal", steal, 1'b0);
    chk("t1_ready", evt_if.evt_ready_o, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_after_active", act, 4'b0000);
    chk("t1_after_trig", trig, 4'b0000);

    // T2: two note-ons fill slots 0 and 1
    send_evt(1'b1, 4'd5, 4'b0001, 1'b0, 1'b0);
    chk("t2_active0", act, 4'b0001);
    chk("t2_notes0", notes, 16'h0005);
    send_evt(1'b1, 4'd9, 4'b0010, 1'b0, 1'b0);
    chk("t2_active1", act, 4'b0011);
    chk("t2_notes1", notes, 16'h0095);

    // T3: duplicate note-on retriggers the existing slot
    send_evt(1'b1, 4'd5, 4'b0001, 1'b0, 1'b0);
    chk("t3_active", act, 4'b0011);
    chk("t3_notes", notes, 16'h0095);

    // T4: full allocation then steal the oldest (slot 0)
    do_reset();
    send_evt(1'b1, 4'd1, 4'b0001, 1'b0, 1'b0);
    send_evt(1'b1, 4'd2, 4'b0010, 1'b0, 1'b0);
    send_evt(1'b1, 4'd3, 4'b0100, 1'b0, 1'b0);
    send_evt(1'b1, 4'd4, 4'b1000, 1'b0, 1'b0);
    chk("t4_full", act, 4'b1111);
    chk("t4_notes_full", notes, 16'h4321);
    send_evt(1'b1, 4'd7, 4'b0001, 1'b1, 1'b0);
    chk("t4_active", act, 4'b1111);
    chk("t4_notes", notes, 16'h4327);

    // T5: release slot 1 (note kept), then refill it without stealing
    send_evt(1'b0, 4'd2, 4'b0000, 1'b0, 1'b0);
    chk("t5_off_active", act, 4'b1101);
    chk("t5_off_notes", notes, 16'h4327);
    send_evt(1'b1, 4'd12, 4'b0010, 1'b0, 1'b0);
    chk("t5_active", act, 4'b1111);
    chk("t5_notes", notes, 16'h43C7);

    // T6a: unmatched note-off with valid held through busy cycles
    hs_ref = hs_cnt;
    send_evt(1'b0, 4'd15, 4'b0000, 1'b0, 1'b1);
    chk("t6_hs_count", 32'(hs_cnt - hs_ref), 32'd1);
    chk("t6_active", act, 4'b1111);
    chk("t6_notes", notes, 16'h43C7);

    // T6b: payload with valid low is not an event
    hs_ref = hs_cnt;
    @(negedge clk);
    evt_if.evt_on_i = 1'b0; evt_if.evt_note_i = 4'd7;
    repeat (4) @(negedge clk);
    chk("t6_novalid_hs", 32'(hs_cnt - hs_ref), 32'd0);
    chk("t6_novalid_active", act, 4'b1111);
    chk("t6_novalid_trig", trig, 4'b0000);

    // T6c: ages saturate; wrapping would make slot 1 the oldest instead of slot 0
    do_reset();
    send_evt(1'b1, 4'd1, 4'b0001, 1'b0, 1'b0);
    send_evt(1'b1, 4'd2, 4'b0010, 1'b0, 1'b0);
    send_evt(1'b1, 4'd3, 4'b0100, 1'b0, 1'b0);
    send_evt(1'b1, 4'd4, 4'b1000, 1'b0, 1'b0);
    send_evt(1'b1, 4'd1, 4'b0001, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) send_evt(1'b1, 4'd4, 4'b1000, 1'b0, 1'b0);
    send_evt(1'b1, 4'd9, 4'b0001, 1'b1, 1'b0);
    chk("t6_sat_notes", notes, 16'h4329);
    chk("t6_sat_active", act, 4'b1111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
